sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Shares one sram-like slave port (to the AXI bridge) between the IF-stage inst master
//  and the EXE-stage data master. Fixed priority (data > inst), grant lock until addr_ok,
//  in-order outstanding-ID FIFO routing data_ok/rdata back to the owning master.
//  Sits between the pipeline stages and the sram-like-to-AXI bridge.
// PARAMETERS
//  DEPTH  4  max accepted-but-not-returned transactions (power of 2, >=2)
//  PTR_W  2  log2(DEPTH)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  inst_req       in   1   inst master request (held until inst_addr_ok)
//  inst_wr        in   1   inst write (normally 0)
//  inst_size      in   2   0=byte 1=half 2=word
//  inst_wstrb     in   4   byte strobes
//  inst_addr      in   32  address
//  inst_wdata     in   32  write data
//  inst_addr_ok   out  1   inst request accepted this cycle
//  inst_data_ok   out  1   inst response this cycle
//  inst_rdata     out  32  inst read data
//  data_req/wr/size/wstrb/addr/wdata  in  1/1/2/4/32/32  data master, same meaning
//  data_addr_ok   out  1   data request accepted this cycle
//  data_data_ok   out  1   data response this cycle
//  data_rdata     out  32  data read data
//  slv_req/wr/size/wstrb/addr/wdata   out 1/1/2/4/32/32  to slave, muxed from granted master
//  slv_addr_ok    in   1   slave accepted slv_req
//  slv_data_ok    in   1   slave response (in order of acceptance)
//  slv_rdata      in   32  slave read data
//  outstanding    out  PTR_W+1  current FIFO occupancy
//  err_unexp      out  1   sticky: slv_data_ok seen with FIFO empty
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, outstanding=0, err_unexp=0; all *_ok and slv_req low.
//  FSM IDLE: if full -> slv_req=0, no grant. Else grant data if data_req, else inst if
//   inst_req; slv_* driven combinationally from grantee same cycle (zero added latency).
//   Grantee req && !slv_addr_ok -> go LOCK_D / LOCK_I (remember grantee).
//  LOCK_x: grant fixed to x regardless of other req; slv_req=x_req. On slv_addr_ok -> IDLE.
//   If x drops req while locked -> IDLE (protocol violation, no push).
//  Accept = slv_req && slv_addr_ok: x_addr_ok=1 for grantee only, push ID (0=inst,1=data).
//  Full: count==DEPTH blocks new grant even if slv_data_ok pops same cycle (no bypass).
//   Full only checked in IDLE; LOCK entered only when not full, so cannot overflow.
//  Return: slv_data_ok && !empty -> head ID selects inst_data_ok or data_data_ok,
//   rdata = slv_rdata to both (only the *_data_ok qualifies), pop head.
//  slv_data_ok && empty -> ignored, err_unexp<=1 until reset.
//  Push+pop same cycle: count unchanged, both pointers advance; pointers wrap mod DEPTH.
//  Slave never returns data_ok for a request in its accept cycle (bridge guarantee).
//  Reset mid-transaction drops FIFO contents; later stray data_ok sets err_unexp.
// TESTING
//  1 Both req in same cycle, slv_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, ID FIFO=[1].
//  2 inst_req, slv_addr_ok low 3 cycles, data_req rises cycle 1 -> slv_addr stays inst_addr
//    until accept; data granted next cycle.
//  3 Accept I,D,I (addr 0x1000,0x2000,0x1004) then 3x slv_data_ok rdata A,B,C ->
//    inst gets A, data gets B, inst gets C; outstanding 3->0.
//  4 Fill 4 outstanding -> slv_req=0 with reqs pending; one data_ok -> next cycle grant resumes.
//  5 Push and pop same cycle at count=2 -> count stays 2; wraps ptr past 3 correctly.
//  6 slv_data_ok at empty -> no *_data_ok, err_unexp=1 and stays 1 until reset.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares one sram-like slave port (towards the sram-like-to-AXI bridge) between
// the IF-stage instruction master and the EXE-stage data master.
//
//   * Fixed priority: data beats inst when both request in IDLE.
//   * Once a master is presented to the slave without being accepted, the grant
//     is locked to that master until slv_addr_ok (or until it withdraws req).
//   * Every accepted request pushes a one-bit owner ID (0=inst, 1=data) into an
//     in-order FIFO; each slv_data_ok pops the head and steers the response to
//     the owning master.
//   * A new grant is refused while the FIFO is full, so the FIFO cannot overflow.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata   instruction master request side
//   inst_addr_ok, inst_data_ok, inst_rdata   instruction master responses
//   data_req/wr/size/wstrb/addr/wdata   data master request side
//   data_addr_ok, data_data_ok, data_rdata   data master responses
//   slv_req/wr/size/wstrb/addr/wdata    muxed request to the slave
//   slv_addr_ok, slv_data_ok, slv_rdata      slave handshakes and read data
//   outstanding                  accepted-but-not-returned transaction count
//   err_unexp                    sticky: slave response seen with nothing pending
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,

    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,

    output logic             slv_req,
    output logic             slv_wr,
    output logic [1:0]       slv_size,
    output logic [3:0]       slv_wstrb,
    output logic [31:0]      slv_addr,
    output logic [31:0]      slv_wdata,
    input  logic             slv_addr_ok,
    input  logic             slv_data_ok,
    input  logic [31:0]      slv_rdata,

    output logic [PTR_W:0]   outstanding,
    output logic             err_unexp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t             state;

    logic [PTR_W:0]     count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DEPTH-1:0]   id_mem;

    logic               full;
    logic               empty;
    logic               grant_i;
    logic               grant_d;
    logic               accept;
    logic               pop;
    logic               head_id;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Grant selection. Full is only consulted in IDLE: a LOCK state is entered
    // only when there was room, so the locked request always fits.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state)
            IDLE: begin
                if (!full) begin
                    if (data_req)      grant_d = 1'b1;
                    else if (inst_req) grant_i = 1'b1;
                end
            end
            LOCK_I:  grant_i = 1'b1;
            LOCK_D:  grant_d = 1'b1;
            default: ;
        endcase
    end

    // Slave request is driven combinationally from the grantee, so a request
    // reaches the bridge in the same cycle it is raised.
    always_comb begin
        slv_req   = (grant_d & data_req) | (grant_i & inst_req);
        slv_wr    = 1'b0;
        slv_size  = 2'd0;
        slv_wstrb = 4'd0;
        slv_addr  = 32'd0;
        slv_wdata = 32'd0;
        if (grant_d) begin
            slv_wr    = data_wr;
            slv_size  = data_size;
            slv_wstrb = data_wstrb;
            slv_addr  = data_addr;
            slv_wdata = data_wdata;
        end else if (grant_i) begin
            slv_wr    = inst_wr;
            slv_size  = inst_size;
            slv_wstrb = inst_wstrb;
            slv_addr  = inst_addr;
            slv_wdata = inst_wdata;
        end
    end

    assign accept       = slv_req & slv_addr_ok;
    assign inst_addr_ok = accept & grant_i;
    assign data_addr_ok = accept & grant_d;

    // Response routing: the head of the ID FIFO names the owner of the
    // response; rdata fans out to both masters and only data_ok qualifies it.
    assign pop          = slv_data_ok & ~empty;
    assign head_id      = id_mem[rd_ptr];
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop &  head_id;
    assign inst_rdata   = slv_rdata;
    assign data_rdata   = slv_rdata;

    assign outstanding  = count;

    // Control state: FSM, FIFO pointers/occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_unexp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d && !slv_addr_ok)      state <= LOCK_D;
                    else if (grant_i && !slv_addr_ok) state <= LOCK_I;
                end
                // Withdrawing req while locked is a master protocol violation;
                // release the lock without pushing anything.
                LOCK_I: begin
                    if (!inst_req || slv_addr_ok) state <= IDLE;
                end
                LOCK_D: begin
                    if (!data_req || slv_addr_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            if (slv_data_ok && empty) err_unexp <= 1'b1;
        end
    end

    // Owner-ID storage: pure data, validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= grant_d;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        slv_req, slv_wr;
    logic [1:0]  slv_size;
    logic [3:0]  slv_wstrb;
    logic [31:0] slv_addr, slv_wdata;
    logic        slv_addr_ok, slv_data_ok;
    logic [31:0] slv_rdata;
    logic [2:0]  outstanding;
    logic        err_unexp;

    int checks = 0;
    int errors = 0;

    sram_like_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .slv_req(slv_req), .slv_wr(slv_wr), .slv_size(slv_size),
        .slv_wstrb(slv_wstrb), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_addr_ok(slv_addr_ok), .slv_data_ok(slv_data_ok), .slv_rdata(slv_rdata),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; checks run #1 later, well
    // before the next rising edge.
    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h0; data_wdata = 32'h0;
        slv_addr_ok = 0; slv_data_ok = 0; slv_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        next_cycle(); next_cycle();
        reset = 0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++;
            $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (err_unexp !== 1'b0) begin errors++;
            $display("FAIL reset_err got %b want 0", err_unexp); end
        checks++; if ({slv_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            errors++; $display("FAIL reset_oks got %b want 00000",
                {slv_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        next_cycle();
    endtask

    task automatic test_priority();
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wdata = 32'hCAFE_0001;
        slv_addr_ok = 1;
        #1;
        checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++;
            $display("FAIL prio_addr_ok got d=%b i=%b want d=1 i=0", data_addr_ok, inst_addr_ok); end
        checks++; if (slv_addr !== 32'h2000 || slv_wr !== 1'b1 || slv_wdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL prio_slv_mux got addr=%h wr=%b wdata=%h want 2000/1/cafe0001",
                slv_addr, slv_wr, slv_wdata); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 3'd1) begin errors++;
            $display("FAIL prio_count got %0d want 1", outstanding); end
        next_cycle();
        slv_data_ok = 1; slv_rdata = 32'hAAAA_0001;
        #1;
        checks++; if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'hAAAA_0001) begin
            errors++; $display("FAIL prio_return got d=%b i=%b rdata=%h want d=1 i=0 aaaa0001",
                data_data_ok, inst_data_ok, data_rdata); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++;
            $display("FAIL prio_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'h1000;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin data_req = 1; data_addr = 32'h2000; end
            #1;
            checks++; if (slv_req !== 1'b1 || slv_addr !== 32'h1000 || data_addr_ok !== 1'b0) begin
                errors++; $display("FAIL lock_hold_c%0d got req=%b addr=%h dok=%b want 1/1000/0",
                    c, slv_req, slv_addr, data_addr_ok); end
            next_cycle();
        end
        slv_addr_ok = 1;
        #1;
        checks++; if (slv_addr !== 32'h1000 || {inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL lock_accept got addr=%h i=%b d=%b want 1000 i=1 d=0",
                slv_addr, inst_addr_ok, data_addr_ok); end
        next_cycle();
        inst_req = 0;
        #1;
        checks++; if (slv_addr !== 32'h2000 || data_addr_ok !== 1'b1) begin errors++;
            $display("FAIL lock_next_grant got addr=%h d=%b want 2000 d=1", slv_addr, data_addr_ok); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (outstanding !== 3'd2) begin errors++;
            $display("FAIL lock_count got %0d want 2", outstanding); end
        slv_data_ok = 1; slv_rdata = 32'h11;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++;
            $display("FAIL lock_ret0 got i=%b d=%b want i=1 d=0", inst_data_ok, data_data_ok); end
        next_cycle();
        slv_rdata = 32'h22;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++;
            $display("FAIL lock_ret1 got i=%b d=%b want i=0 d=1", inst_data_ok, data_data_ok); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock_drop();
        inst_req = 1; inst_addr = 32'h3000;
        next_cycle();
        inst_req = 0; data_req = 1; data_addr = 32'h4000; slv_addr_ok = 1;
        #1;
        checks++; if (slv_req !== 1'b0 || data_addr_ok !== 1'b0) begin errors++;
            $display("FAIL drop_locked got req=%b d=%b want 0/0", slv_req, data_addr_ok); end
        next_cycle();
        #1;
        checks++; if (outstanding !== 3'd0 || data_addr_ok !== 1'b1 || slv_addr !== 32'h4000) begin
            errors++; $display("FAIL drop_release got cnt=%0d d=%b addr=%h want 0/1/4000",
                outstanding, data_addr_ok, slv_addr); end
        next_cycle();
        idle_inputs();
        slv_data_ok = 1;
        #1;
        checks++; if (data_data_ok !== 1'b1) begin errors++;
            $display("FAIL drop_ret got d=%b want 1", data_data_ok); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_order();
        logic [31:0] addrs [3];
        logic        is_d  [3];
        logic [31:0] rd    [3];
        addrs = '{32'h1000, 32'h2000, 32'h1004};
        is_d  = '{1'b0, 1'b1, 1'b0};
        rd    = '{32'hA, 32'hB, 32'hC};
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            slv_addr_ok = 1;
            if (is_d[k]) begin data_req = 1; data_addr = addrs[k]; end
            else begin inst_req = 1; inst_addr = addrs[k]; end
            #1;
            checks++; if (slv_addr !== addrs[k] || {data_addr_ok, inst_addr_ok} !== {is_d[k], !is_d[k]}) begin
                errors++; $display("FAIL order_acc%0d got addr=%h d=%b i=%b want %h d=%b",
                    k, slv_addr, data_addr_ok, inst_addr_ok, addrs[k], is_d[k]); end
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++; if (outstanding !== 3'd3) begin errors++;
            $display("FAIL order_count got %0d want 3", outstanding); end
        for (int k = 0; k < 3; k++) begin
            slv_data_ok = 1; slv_rdata = rd[k];
            #1;
            checks++; if ({data_data_ok, inst_data_ok} !== {is_d[k], !is_d[k]}
                          || (is_d[k] ? data_rdata : inst_rdata) !== rd[k]) begin
                errors++; $display("FAIL order_ret%0d got d=%b i=%b rdata=%h want d=%b %h",
                    k, data_data_ok, inst_data_ok, slv_rdata, is_d[k], rd[k]); end
            next_cycle();
            slv_data_ok = 0;
            #1;
            checks++; if (outstanding !== 3'(2 - k)) begin errors++;
                $display("FAIL order_cnt%0d got %0d want %0d", k, outstanding, 2 - k); end
        end
        idle_inputs();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            data_req = 1; data_addr = 32'h5000 + 32'(k * 4); slv_addr_ok = 1;
            next_cycle();
        end
        #1;
        checks++; if (outstanding !== 3'd4) begin errors++;
            $display("FAIL full_count got %0d want 4", outstanding); end
        inst_req = 1; inst_addr = 32'h6000;
        #1;
        checks++; if (slv_req !== 1'b0 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
            errors++; $display("FAIL full_block got req=%b d=%b i=%b want 0", slv_req, data_addr_ok, inst_addr_ok); end
        next_cycle();
        slv_data_ok = 1; slv_rdata = 32'h77;
        #1;
        checks++; if (slv_req !== 1'b0 || data_data_ok !== 1'b1) begin errors++;
            $display("FAIL full_nobypass got req=%b dok=%b want 0/1", slv_req, data_data_ok); end
        next_cycle();
        slv_data_ok = 0;
        #1;
        checks++; if (slv_req !== 1'b1 || data_addr_ok !== 1'b1 || outstanding !== 3'd3) begin
            errors++; $display("FAIL full_resume got req=%b d=%b cnt=%0d want 1/1/3",
                slv_req, data_addr_ok, outstanding); end
        next_cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            slv_data_ok = 1;
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++;
            $display("FAIL full_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_push_pop();
        inst_req = 1; slv_addr_ok = 1;
        next_cycle();
        inst_req = 0; data_req = 1;
        next_cycle();
        // FIFO now [I,D]; each cycle pushes the owner just popped.
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            slv_addr_ok = 1; slv_data_ok = 1; slv_rdata = 32'h100 + 32'(k);
            if (k % 2 == 0) inst_req = 1; else data_req = 1;
            #1;
            checks++; if ({inst_data_ok, data_data_ok} !== ((k % 2 == 0) ? 2'b10 : 2'b01)
                          || (inst_addr_ok | data_addr_ok) !== 1'b1) begin
                errors++; $display("FAIL pp_route%0d got iok=%b dok=%b acc=%b want alt route acc=1",
                    k, inst_data_ok, data_data_ok, inst_addr_ok | data_addr_ok); end
            next_cycle();
            idle_inputs();
            #1;
            checks++; if (outstanding !== 3'd2) begin errors++;
                $display("FAIL pp_count%0d got %0d want 2", k, outstanding); end
        end
        slv_data_ok = 1;
        #1;
        checks++; if (inst_data_ok !== 1'b1) begin errors++;
            $display("FAIL pp_tail0 got %b want 1", inst_data_ok); end
        next_cycle();
        #1;
        checks++; if (data_data_ok !== 1'b1) begin errors++;
            $display("FAIL pp_tail1 got %b want 1", data_data_ok); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_unexp();
        slv_data_ok = 1; slv_rdata = 32'hDEAD;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++;
            $display("FAIL unexp_oks got %b want 00", {inst_data_ok, data_data_ok}); end
        next_cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (err_unexp !== 1'b1 || outstanding !== 3'd0) begin errors++;
                $display("FAIL unexp_sticky%0d got err=%b cnt=%0d want 1/0", k, err_unexp, outstanding); end
            next_cycle();
        end
        reset = 1;
        next_cycle();
        reset = 0;
        #1;
        checks++; if (err_unexp !== 1'b0) begin errors++;
            $display("FAIL unexp_clear got %b want 0", err_unexp); end
        // Reset with a transaction in flight drops it; its late response is stray.
        inst_req = 1; slv_addr_ok = 1;
        next_cycle();
        idle_inputs();
        reset = 1;
        next_cycle();
        reset = 0;
        #1;
        checks++; if (outstanding !== 3'd0) begin errors++;
            $display("FAIL midrst_count got %0d want 0", outstanding); end
        slv_data_ok = 1;
        #1;
        checks++; if (inst_data_ok !== 1'b0) begin errors++;
            $display("FAIL midrst_iok got %b want 0", inst_data_ok); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (err_unexp !== 1'b1) begin errors++;
            $display("FAIL midrst_err got %b want 1", err_unexp); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_priority();
        next_cycle();
        test_lock();
        test_lock_drop();
        test_order();
        test_full();
        test_push_pop();
        test_unexp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
